// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive packet engine: FSM states,
// PID values, error codes and the serial CRC step functions.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_TOKEN,
    ST_DATA,
    ST_WAIT_EOP,
    ST_DRAIN
  } state_e;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_SYNC = 3'd1;
  localparam logic [2:0] ERR_PID  = 3'd2;
  localparam logic [2:0] ERR_CRC  = 3'd3;
  localparam logic [2:0] ERR_LEN  = 3'd4;
  localparam logic [2:0] ERR_OVF  = 3'd5;

  localparam logic [4:0]  CRC5_POLY      = 5'h05;
  localparam logic [4:0]  CRC5_INIT      = 5'h1F;
  localparam logic [4:0]  CRC5_RESIDUAL  = 5'h0C;
  localparam logic [15:0] CRC16_POLY     = 16'h8005;
  localparam logic [15:0] CRC16_INIT     = 16'hFFFF;
  localparam logic [15:0] CRC16_RESIDUAL = 16'h800D;

  function automatic logic [4:0] crc5_next(input logic [4:0] c, input logic b);
    return {c[3:0], 1'b0} ^ (((b ^ c[4]) == 1'b1) ? CRC5_POLY : 5'h00);
  endfunction

  function automatic logic [15:0] crc16_next(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ (((b ^ c[15]) == 1'b1) ? CRC16_POLY : 16'h0000);
  endfunction

endpackage

// File: rtl/usb_rx_commit_fifo.sv
// Byte FIFO whose readers only see the committed region; the write pointer
// can be rolled back to the last commit point to discard a bad packet.
module usb_rx_commit_fifo
  import usb_rx_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     commit,
  input  logic                     rollback,
  input  logic                     rd_en,
  output logic [7:0]               rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] commit_ptr_q, commit_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] used;
  logic        do_wr, do_rd;

  always_comb begin
    count        = commit_ptr_q - rd_ptr_q;
    used         = wr_ptr_q - rd_ptr_q;
    empty        = (count == '0);
    full         = (used == FULL_CNT);
    do_wr        = wr_en && !full && !rollback;
    do_rd        = rd_en && !empty;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    rd_data_d    = rd_data_q;
    if (rollback) begin
      wr_ptr_d = commit_ptr_q;
    end else if (do_wr) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (commit) begin
      commit_ptr_d = wr_ptr_q;
    end
    if (do_rd) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_data_d = mem_q[rd_ptr_q[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      rd_data_q    <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/usb_rx_packet_engine.sv
// USB receive packet engine: SYNC/PID checking, token decode with CRC5 and
// address filter, CRC16-checked data payload buffered with commit/rollback.
module usb_rx_packet_engine
  import usb_rx_pkg::*;
#(
  parameter int FIFO_DEPTH     = 64,
  parameter int MAX_PAYLOAD    = 64,
  parameter bit ADDR_FILTER_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          bit_valid,
  input  logic                          bit_in,
  input  logic                          eop,
  input  logic [6:0]                    dev_addr,
  output logic [3:0]                    rx_pid,
  output logic [6:0]                    tok_addr,
  output logic [3:0]                    tok_endp,
  output logic                          packet_done,
  output logic                          packet_err,
  output logic [2:0]                    err_code,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          fifo_empty,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CNT_W = $clog2((MAX_PAYLOAD + 3) * 8 + 1);
  localparam int PAY_W = $clog2(MAX_PAYLOAD + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [15:0]        sr_q, sr_d, sr_shift;
  logic [4:0]         crc5_q, crc5_d;
  logic [15:0]        crc16_q, crc16_d;
  logic [7:0]         hold0_q, hold0_d, hold1_q, hold1_d;
  logic [1:0]         hold_cnt_q, hold_cnt_d;
  logic [PAY_W-1:0]   pay_cnt_q, pay_cnt_d;
  logic [3:0]         pid_q, pid_d;
  logic [2:0]         code_q, code_d;
  logic               packet_done_q, packet_done_d;
  logic               packet_err_q, packet_err_d;
  logic [2:0]         err_code_q, err_code_d;
  logic [3:0]         rx_pid_q, rx_pid_d;
  logic [6:0]         tok_addr_q, tok_addr_d;
  logic [3:0]         tok_endp_q, tok_endp_d;
  logic               wr_en, commit, rollback, fifo_full;
  logic [7:0]         wr_data, pid_byte;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sr_shift      = {bit_in, sr_q[15:1]};
    sr_d          = sr_q;
    crc5_d        = crc5_q;
    crc16_d       = crc16_q;
    hold0_d       = hold0_q;
    hold1_d       = hold1_q;
    hold_cnt_d    = hold_cnt_q;
    pay_cnt_d     = pay_cnt_q;
    pid_d         = pid_q;
    code_d        = code_q;
    packet_done_d = 1'b0;
    packet_err_d  = 1'b0;
    err_code_d    = err_code_q;
    rx_pid_d      = rx_pid_q;
    tok_addr_d    = tok_addr_q;
    tok_endp_d    = tok_endp_q;
    wr_en         = 1'b0;
    wr_data       = hold0_q;
    commit        = 1'b0;
    rollback      = 1'b0;
    pid_byte      = sr_shift[15:8];

    if (eop) begin
      state_d = ST_IDLE;
      case (state_q)
        ST_IDLE: ;
        ST_SYNC, ST_PID: begin
          packet_err_d = 1'b1;
          err_code_d   = ERR_LEN;
        end
        ST_TOKEN: begin
          if (cnt_q != CNT_W'(16)) begin
            packet_err_d = 1'b1;
            err_code_d   = ERR_LEN;
          end else if (crc5_q != CRC5_RESIDUAL) begin
            packet_err_d = 1'b1;
            err_code_d   = ERR_CRC;
          end else if (!(ADDR_FILTER_EN && (sr_q[6:0] != dev_addr))) begin
            packet_done_d = 1'b1;
            rx_pid_d      = pid_q;
            tok_addr_d    = sr_q[6:0];
            tok_endp_d    = sr_q[10:7];
          end
        end
        ST_DATA: begin
          if ((cnt_q[2:0] != 3'd0) || (cnt_q < CNT_W'(16))) begin
            packet_err_d = 1'b1;
            err_code_d   = ERR_LEN;
            rollback     = 1'b1;
          end else if (crc16_q != CRC16_RESIDUAL) begin
            packet_err_d = 1'b1;
            err_code_d   = ERR_CRC;
            rollback     = 1'b1;
          end else begin
            packet_done_d = 1'b1;
            rx_pid_d      = pid_q;
            commit        = 1'b1;
          end
        end
        ST_WAIT_EOP: begin
          packet_done_d = 1'b1;
          rx_pid_d      = pid_q;
        end
        ST_DRAIN: begin
          packet_err_d = 1'b1;
          err_code_d   = code_q;
        end
        default: ;
      endcase
    end else if (bit_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (bit_in) begin
            state_d = ST_DRAIN;
            code_d  = ERR_SYNC;
          end else begin
            state_d = ST_SYNC;
            cnt_d   = CNT_W'(1);
          end
        end
        ST_SYNC: begin
          if (bit_in != (cnt_q == CNT_W'(7))) begin
            state_d = ST_DRAIN;
            code_d  = ERR_SYNC;
          end else if (cnt_q == CNT_W'(7)) begin
            state_d = ST_PID;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_PID: begin
          sr_d  = sr_shift;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(7)) begin
            pid_d      = pid_byte[3:0];
            cnt_d      = '0;
            crc5_d     = CRC5_INIT;
            crc16_d    = CRC16_INIT;
            hold_cnt_d = 2'd0;
            pay_cnt_d  = '0;
            code_d     = ERR_PID;
            if (pid_byte[7:4] != ~pid_byte[3:0]) begin
              state_d = ST_DRAIN;
            end else begin
              case (pid_byte[3:0])
                PID_OUT, PID_IN, PID_SETUP: state_d = ST_TOKEN;
                PID_DATA0, PID_DATA1:       state_d = ST_DATA;
                PID_ACK, PID_NAK, PID_STALL: state_d = ST_WAIT_EOP;
                default:                    state_d = ST_DRAIN;
              endcase
            end
          end
        end
        ST_TOKEN: begin
          if (cnt_q == CNT_W'(16)) begin
            state_d = ST_DRAIN;
            code_d  = ERR_LEN;
          end else begin
            sr_d   = sr_shift;
            crc5_d = crc5_next(crc5_q, bit_in);
            cnt_d  = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          sr_d    = sr_shift;
          crc16_d = crc16_next(crc16_q, bit_in);
          cnt_d   = cnt_q + 1'b1;
          // Two completed bytes stay held back so the CRC never reaches the FIFO.
          if (cnt_q[2:0] == 3'd7) begin
            case (hold_cnt_q)
              2'd0: begin
                hold0_d    = sr_shift[15:8];
                hold_cnt_d = 2'd1;
              end
              2'd1: begin
                hold1_d    = sr_shift[15:8];
                hold_cnt_d = 2'd2;
              end
              default: begin
                if (fifo_full || (pay_cnt_q == PAY_W'(MAX_PAYLOAD))) begin
                  state_d  = ST_DRAIN;
                  code_d   = ERR_OVF;
                  rollback = 1'b1;
                end else begin
                  wr_en     = 1'b1;
                  hold0_d   = hold1_q;
                  hold1_d   = sr_shift[15:8];
                  pay_cnt_d = pay_cnt_q + 1'b1;
                end
              end
            endcase
          end
        end
        ST_WAIT_EOP: begin
          state_d = ST_DRAIN;
          code_d  = ERR_LEN;
        end
        ST_DRAIN: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q       <= ST_IDLE;
      code_q        <= ERR_NONE;
      packet_done_q <= 1'b0;
      packet_err_q  <= 1'b0;
      err_code_q    <= ERR_NONE;
      rx_pid_q      <= '0;
      tok_addr_q    <= '0;
      tok_endp_q    <= '0;
    end else begin
      state_q       <= state_d;
      code_q        <= code_d;
      packet_done_q <= packet_done_d;
      packet_err_q  <= packet_err_d;
      err_code_q    <= err_code_d;
      rx_pid_q      <= rx_pid_d;
      tok_addr_q    <= tok_addr_d;
      tok_endp_q    <= tok_endp_d;
    end
  end

  // Datapath registers are (re)initialised on state entry, so no reset.
  always_ff @(posedge clk) begin
    cnt_q      <= cnt_d;
    sr_q       <= sr_d;
    crc5_q     <= crc5_d;
    crc16_q    <= crc16_d;
    hold0_q    <= hold0_d;
    hold1_q    <= hold1_d;
    hold_cnt_q <= hold_cnt_d;
    pay_cnt_q  <= pay_cnt_d;
    pid_q      <= pid_d;
  end

  usb_rx_commit_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .n_rst    (n_rst),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .commit   (commit),
    .rollback (rollback),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign rx_pid      = rx_pid_q;
  assign tok_addr    = tok_addr_q;
  assign tok_endp    = tok_endp_q;
  assign packet_done = packet_done_q;
  assign packet_err  = packet_err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_usb_rx_packet_engine.sv
// Directed bench for usb_rx_packet_engine: tokens, data packets with commit
// and rollback, overflow, PID/SYNC/length errors, and mid-packet reset.
module tb_usb_rx_packet_engine;

  logic       clk = 1'b0;
  logic       n_rst, bit_valid, bit_in, eop, rd_en;
  logic [6:0] dev_addr;
  logic [3:0] rx_pid, tok_endp;
  logic [6:0] tok_addr;
  logic       packet_done, packet_err, fifo_empty;
  logic [2:0] err_code;
  logic [7:0] rd_data;
  logic [6:0] fifo_count;

  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] pay [0:31];

  always #5 clk = ~clk;

  usb_rx_packet_engine #(
    .FIFO_DEPTH(64), .MAX_PAYLOAD(16), .ADDR_FILTER_EN(1'b1)
  ) dut (
    .clk(clk), .n_rst(n_rst), .bit_valid(bit_valid), .bit_in(bit_in), .eop(eop),
    .dev_addr(dev_addr), .rx_pid(rx_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .packet_done(packet_done), .packet_err(packet_err), .err_code(err_code),
    .rd_en(rd_en), .rd_data(rd_data), .fifo_empty(fifo_empty), .fifo_count(fifo_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic b);
    crc5_step = {c[3:0], 1'b0};
    if (b ^ c[4]) crc5_step = crc5_step ^ 5'h05;
  endfunction

  function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
    crc16_step = {c[14:0], 1'b0};
    if (b ^ c[15]) crc16_step = crc16_step ^ 16'h8005;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    bit_in    = b;
    tick();
    bit_valid = 1'b0;
    bit_in    = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic send_pid(input logic [3:0] p);
    send_byte(8'h80);
    send_byte({~p, p});
  endtask

  task automatic send_eop(input bit rd);
    eop   = 1'b1;
    rd_en = rd;
    tick();
    eop   = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic send_token(input logic [3:0] p, input logic [6:0] a,
                            input logic [3:0] e, input bit bad);
    logic [10:0] f;
    logic [4:0]  c;
    f = {e, a};
    c = 5'h1F;
    for (int i = 0; i < 11; i++) c = crc5_step(c, f[i]);
    if (bad) c[0] = ~c[0];
    send_pid(p);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    for (int k = 4; k >= 0; k--) send_bit(~c[k]);
    send_eop(1'b0);
  endtask

  task automatic send_data(input logic [3:0] p, input int n, input bit flip, input bit rd);
    logic [15:0] c;
    logic [7:0]  b;
    c = 16'hFFFF;
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 8; j++) c = crc16_step(c, pay[i][j]);
    send_pid(p);
    for (int i = 0; i < n; i++) begin
      b = pay[i];
      if (flip && i == 0) b = b ^ 8'h04;
      send_byte(b);
    end
    for (int k = 15; k >= 0; k--) send_bit(~c[k]);
    send_eop(rd);
  endtask

  task automatic rd_byte(input string tag, input logic [7:0] exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    chk(tag, rd_data, exp);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_pid"}, rx_pid, 4'h0);
    chk({tag, "_tok_addr"}, tok_addr, 7'h0);
    chk({tag, "_tok_endp"}, tok_endp, 4'h0);
    chk({tag, "_done"}, packet_done, 1'b0);
    chk({tag, "_err"}, packet_err, 1'b0);
    chk({tag, "_err_code"}, err_code, 3'd0);
    chk({tag, "_rd_data"}, rd_data, 8'h00);
    chk({tag, "_empty"}, fifo_empty, 1'b1);
    chk({tag, "_count"}, fifo_count, 7'd0);
  endtask

  initial begin
    n_rst = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; eop = 1'b0; rd_en = 1'b0;
    dev_addr = 7'h05;
    repeat (2) tick();
    chk_reset_outputs("rst");
    n_rst = 1'b1;
    tick();

    // Good OUT token to our address
    send_token(4'b0001, 7'h05, 4'h1, 1'b0);
    chk("tok_done", packet_done, 1'b1);
    chk("tok_err", packet_err, 1'b0);
    chk("tok_pid", rx_pid, 4'h1);
    chk("tok_addr", tok_addr, 7'h05);
    chk("tok_endp", tok_endp, 4'h1);
    tick();
    chk("tok_done_pulse", packet_done, 1'b0);

    // Token for another device is silently dropped
    dev_addr = 7'h06;
    send_token(4'b1001, 7'h05, 4'h2, 1'b0);
    chk("filt_done", packet_done, 1'b0);
    chk("filt_err", packet_err, 1'b0);
    chk("filt_endp", tok_endp, 4'h1);
    chk("filt_pid", rx_pid, 4'h1);
    dev_addr = 7'h05;

    send_token(4'b0001, 7'h05, 4'h3, 1'b1);
    chk("tokcrc_err", packet_err, 1'b1);
    chk("tokcrc_code", err_code, 3'd3);
    chk("tokcrc_endp", tok_endp, 4'h1);

    // DATA0 01 02 03
    pay[0] = 8'h01; pay[1] = 8'h02; pay[2] = 8'h03;
    send_data(4'b0011, 3, 1'b0, 1'b0);
    chk("d0_done", packet_done, 1'b1);
    chk("d0_pid", rx_pid, 4'h3);
    chk("d0_count", fifo_count, 7'd3);
    chk("d0_empty", fifo_empty, 1'b0);
    rd_byte("d0_rd0", 8'h01);
    rd_byte("d0_rd1", 8'h02);
    rd_byte("d0_rd2", 8'h03);
    chk("d0_empty_after", fifo_empty, 1'b1);
    rd_byte("d0_rd_empty_hold", 8'h03);
    chk("d0_count_after", fifo_count, 7'd0);

    send_data(4'b0011, 3, 1'b1, 1'b0);
    chk("d0bad_err", packet_err, 1'b1);
    chk("d0bad_done", packet_done, 1'b0);
    chk("d0bad_code", err_code, 3'd3);
    chk("d0bad_count", fifo_count, 7'd0);

    // Overflow rolls back only the offending packet
    pay[0] = 8'hAA; pay[1] = 8'hBB;
    send_data(4'b0011, 2, 1'b0, 1'b0);
    chk("pre_ovf_count", fifo_count, 7'd2);
    for (int i = 0; i < 17; i++) pay[i] = 8'h10 + 8'(i);
    send_data(4'b1011, 17, 1'b0, 1'b0);
    chk("ovf_err", packet_err, 1'b1);
    chk("ovf_code", err_code, 3'd5);
    chk("ovf_count", fifo_count, 7'd2);
    tick();
    chk("ovf_err_once", packet_err, 1'b0);
    send_data(4'b1011, 16, 1'b0, 1'b0);
    chk("max_done", packet_done, 1'b1);
    chk("max_pid", rx_pid, 4'hB);
    chk("max_count", fifo_count, 7'd18);
    rd_byte("ovf_rd0", 8'hAA);
    rd_byte("ovf_rd1", 8'hBB);
    for (int i = 0; i < 16; i++) rd_byte($sformatf("max_rd%0d", i), 8'h10 + 8'(i));
    chk("max_empty", fifo_empty, 1'b1);

    send_data(4'b1011, 0, 1'b0, 1'b0);
    chk("zlp_done", packet_done, 1'b1);
    chk("zlp_count", fifo_count, 7'd0);

    // Read in the same cycle as a commit
    pay[0] = 8'h5A;
    send_data(4'b0011, 1, 1'b0, 1'b0);
    chk("rc_pre_count", fifo_count, 7'd1);
    pay[0] = 8'hC1; pay[1] = 8'hC2; pay[2] = 8'hC3;
    send_data(4'b0011, 3, 1'b0, 1'b1);
    chk("rc_done", packet_done, 1'b1);
    chk("rc_count", fifo_count, 7'd3);
    chk("rc_rd", rd_data, 8'h5A);
    rd_byte("rc_rd0", 8'hC1);
    rd_byte("rc_rd1", 8'hC2);
    rd_byte("rc_rd2", 8'hC3);

    send_byte(8'h80);
    send_byte(8'hA5);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    send_eop(1'b0);
    chk("pidA5_err", packet_err, 1'b1);
    chk("pidA5_done", packet_done, 1'b0);
    chk("pidA5_code", err_code, 3'd2);
    tick();
    chk("pidA5_once", packet_err, 1'b0);

    send_byte(8'h80);
    send_byte(8'h33);
    send_eop(1'b0);
    chk("pid33_code", err_code, 3'd2);
    chk("pid33_err", packet_err, 1'b1);

    send_pid(4'b0010);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    send_eop(1'b0);
    chk("ackx_err", packet_err, 1'b1);
    chk("ackx_code", err_code, 3'd4);
    chk("ackx_done", packet_done, 1'b0);

    send_byte(8'h40);
    send_byte(8'hD2);
    send_eop(1'b0);
    chk("sync_err", packet_err, 1'b1);
    chk("sync_code", err_code, 3'd1);

    send_byte(8'h80);
    send_bit(1'b1); send_bit(1'b0);
    send_eop(1'b0);
    chk("pid_eop_code", err_code, 3'd4);

    // Reset in the middle of a data packet
    pay[0] = 8'h77; pay[1] = 8'h88;
    send_data(4'b0011, 2, 1'b0, 1'b0);
    chk("mr_pre_count", fifo_count, 7'd2);
    rd_byte("mr_rd", 8'h77);
    send_pid(4'b0011);
    send_byte(8'h99);
    n_rst = 1'b0;
    tick();
    chk_reset_outputs("midrst");
    n_rst = 1'b1;
    tick();
    send_pid(4'b0010);
    send_eop(1'b0);
    chk("ack_done", packet_done, 1'b1);
    chk("ack_pid", rx_pid, 4'h2);
    chk("ack_count", fifo_count, 7'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
